// File: rtl/uart_tx_unit.sv
// UART transmitter: one byte per Send, fixed 11-slot frame (start, D0..D7, parity, stop).
// Bit timing comes from an internal baud counter whose divisor is latched with the request.
module uart_tx_unit #(
  parameter int ClockHz = 50_000_000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Send,
  input  logic [7:0] DataIn,
  input  logic [1:0] ParityType,
  input  logic [1:0] BaudRate,
  output logic       DataTx,
  output logic       Busy,
  output logic       Done
);

  // Nearest-integer divisors; at 50 MHz these are 20833/10417/5208/2604.
  localparam logic [14:0] DivM1_2400  = 15'((ClockHz + 1200) / 2400 - 1);
  localparam logic [14:0] DivM1_4800  = 15'((ClockHz + 2400) / 4800 - 1);
  localparam logic [14:0] DivM1_9600  = 15'((ClockHz + 4800) / 9600 - 1);
  localparam logic [14:0] DivM1_19200 = 15'((ClockHz + 9600) / 19200 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      state_q, state_d;
  logic [14:0] cnt_q, cnt_d;
  logic [14:0] div_m1_q, div_m1_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic        par_q, par_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        bit_end;
  logic [2:0]  idx_nxt;
  logic [14:0] div_m1_sel;
  logic        par_sel;

  assign bit_end = (cnt_q == div_m1_q);
  assign idx_nxt = idx_q + 3'd1;

  always_comb begin
    div_m1_sel = DivM1_2400;
    case (BaudRate)
      2'b00: div_m1_sel = DivM1_2400;
      2'b01: div_m1_sel = DivM1_4800;
      2'b10: div_m1_sel = DivM1_9600;
      2'b11: div_m1_sel = DivM1_19200;
      default: div_m1_sel = DivM1_2400;
    endcase
  end

  always_comb begin
    par_sel = 1'b1;
    case (ParityType)
      2'b01:   par_sel = ~^DataIn;
      2'b10:   par_sel = ^DataIn;
      default: par_sel = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 15'd1;
    div_m1_d = div_m1_q;
    idx_d    = idx_q;
    data_d   = data_q;
    par_d    = par_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d  = 15'd0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (Send) begin
          state_d  = START;
          div_m1_d = div_m1_sel;
          data_d   = DataIn;
          par_d    = par_sel;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          cnt_d   = 15'd0;
          idx_d   = 3'd0;
          tx_d    = data_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = 15'd0;
          if (idx_q == 3'd7) begin
            state_d = PARITY;
            tx_d    = par_q;
          end else begin
            idx_d = idx_nxt;
            tx_d  = data_q[idx_nxt];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          cnt_d   = 15'd0;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          cnt_d   = 15'd0;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 15'd0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= 15'd0;
      div_m1_q <= 15'd0;
      idx_q    <= 3'd0;
      data_q   <= 8'd0;
      par_q    <= 1'b1;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_m1_q <= div_m1_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign DataTx = tx_q;
  assign Busy   = busy_q;
  assign Done   = done_q;

endmodule

// File: tb/tb_uart_tx_unit.sv
// Bench for uart_tx_unit at a scaled 1 MHz clock (divisors 417/208/104/52 by nearest-integer rounding).
// Directed frames from a vector table plus random frames checked against a frame model.
module tb_uart_tx_unit;

  localparam int ClockHz = 1_000_000;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Send;
  logic [7:0] DataIn;
  logic [1:0] ParityType;
  logic [1:0] BaudRate;
  logic       DataTx;
  logic       Busy;
  logic       Done;

  int errors = 0;
  int checks = 0;

  uart_tx_unit #(.ClockHz(ClockHz)) dut (
    .Clock(Clock), .Reset(Reset), .Send(Send), .DataIn(DataIn),
    .ParityType(ParityType), .BaudRate(BaudRate),
    .DataTx(DataTx), .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [7:0]  d;
    logic [1:0]  p;
    logic [1:0]  b;
    logic [10:0] exp;  // bit i = line level in slot i
  } vec_t;

  int div_tab[4] = '{417, 208, 104, 52};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference frame built straight from the framing rules.
  function automatic logic [10:0] frame_model(input logic [7:0] d, input logic [1:0] p);
    logic [10:0] f;
    int ones;
    ones = $countones(d);
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    if (p == 2'b01)      f[9] = (ones % 2 == 0);
    else if (p == 2'b10) f[9] = (ones % 2 == 1);
    else                 f[9] = 1'b1;
    f[10] = 1'b1;
    return f;
  endfunction

  // Called between edges; returns #1 after the Done edge.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] p, input logic [1:0] b,
                            input logic [10:0] exp, input string tag);
    int div;
    int bad [11];
    div = div_tab[b];
    for (int s = 0; s < 11; s++) bad[s] = 0;
    Send = 1'b1; DataIn = d; ParityType = p; BaudRate = b;
    @(posedge Clock); #1;
    chk({tag, " accept DataTx"}, 32'(DataTx), 32'd0);
    chk({tag, " accept Busy"},   32'(Busy),   32'd1);
    chk({tag, " accept Done"},   32'(Done),   32'd0);
    for (int j = 0; j < 11 * div; j++) begin
      if (j > 0) begin
        @(posedge Clock); #1;
      end
      if (DataTx !== exp[j / div] || Busy !== 1'b1 || Done !== 1'b0) bad[j / div]++;
      // Ignored requests and changing inputs while the frame is in flight.
      DataIn     = 8'($urandom);
      ParityType = 2'($urandom);
      BaudRate   = 2'($urandom);
      Send       = ($urandom_range(0, 7) == 0);
    end
    for (int s = 0; s < 11; s++)
      chk($sformatf("%s slot%0d bad cycles", tag, s), 32'(bad[s]), 32'd0);
    @(posedge Clock); #1;
    chk({tag, " end Done"},   32'(Done),   32'd1);
    chk({tag, " end Busy"},   32'(Busy),   32'd0);
    chk({tag, " end DataTx"}, 32'(DataTx), 32'd1);
    Send = 1'b0;
  endtask

  task automatic check_idle(input string tag, input int cycles);
    int bad;
    bad = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge Clock); #1;
      if (DataTx !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0) bad++;
    end
    chk({tag, " idle bad cycles"}, 32'(bad), 32'd0);
  endtask

  vec_t tab [7];

  initial begin
    logic [7:0] rd;
    logic [1:0] rp, rb;

    tab[0] = '{8'h55, 2'b01, 2'b10, 11'b1_1_01010101_0};
    tab[1] = '{8'hA5, 2'b10, 2'b01, 11'b1_0_10100101_0};
    tab[2] = '{8'hFF, 2'b00, 2'b11, 11'b1_1_11111111_0};
    tab[3] = '{8'hFF, 2'b11, 2'b11, 11'b1_1_11111111_0};
    tab[4] = '{8'h3C, 2'b10, 2'b00, 11'b1_0_00111100_0};
    tab[5] = '{8'h00, 2'b01, 2'b10, 11'b1_1_00000000_0};
    tab[6] = '{8'h5A, 2'b01, 2'b10, 11'b1_1_01011010_0};

    Reset = 1'b1; Send = 1'b0; DataIn = 8'h00; ParityType = 2'b00; BaudRate = 2'b00;
    repeat (3) @(posedge Clock);
    #1;
    chk("reset DataTx", 32'(DataTx), 32'd1);
    chk("reset Busy",   32'(Busy),   32'd0);
    chk("reset Done",   32'(Done),   32'd0);
    @(negedge Clock); Reset = 1'b0;
    check_idle("post-reset", 5);

    // Table entries run back-to-back: each accept lands on the edge right after Done.
    for (int i = 0; i < 7; i++)
      send_frame(tab[i].d, tab[i].p, tab[i].b, tab[i].exp, $sformatf("vec%0d", i));
    check_idle("after table", 8);

    // Reset in the middle of D3 of a 9600 frame, then a clean 0x81 frame.
    Send = 1'b1; DataIn = 8'hC3; ParityType = 2'b01; BaudRate = 2'b10;
    @(posedge Clock); #1;
    Send = 1'b0;
    repeat (4 * 104 + 50) @(posedge Clock);
    #3;
    chk("pre-reset DataTx D3", 32'(DataTx), 32'd0);
    Reset = 1'b1;
    #1;
    chk("async reset DataTx", 32'(DataTx), 32'd1);
    chk("async reset Busy",   32'(Busy),   32'd0);
    chk("async reset Done",   32'(Done),   32'd0);
    @(negedge Clock); @(negedge Clock); Reset = 1'b0;
    check_idle("after mid reset", 4);
    send_frame(8'h81, 2'b01, 2'b10, 11'b1_1_10000001_0, "after-reset 81");
    check_idle("after 81", 3);

    // Random frames against the frame model.
    for (int k = 0; k < 6; k++) begin
      rd = 8'($urandom);
      rp = 2'($urandom_range(0, 3));
      rb = 2'($urandom_range(0, 3));
      send_frame(rd, rp, rb, frame_model(rd, rp), $sformatf("rand%0d d=%02h p=%0d b=%0d", k, rd, rp, rb));
      if (k % 2 == 1) check_idle($sformatf("rand%0d gap", k), 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
